instr_sequencer: RTL and testbench

- Program store and fetch sequencer that drives the 9-bit Instruction input of the 4-bit cpu. It replaces the hand-written testbench instruction stream.
- Software or a bench loads up to DEPTH instruction words while the block is idle.
- A start pulse then issues them in order, one per CLK cycle, with hold/abort control and a done indication.
- Instruction format is the cpu's: [8:6] op, [5:4] rs or imm[3:2], [3:2] rt or imm[1:0], [1:0] rd.
- Op encodings: AND 000, OR 001, ADD 010, SUB 110, SLT 111, LI 100.

---
 rtl/instr_sequencer_pkg.sv | 25 ++
 rtl/instr_sequencer_store.sv | 26 ++
 rtl/instr_sequencer.sv | 153 +++++++++++++++
 tb/tb_instr_sequencer.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/instr_sequencer_pkg.sv
// Shared constants for the instruction sequencer: instruction width, cpu opcodes,
// the NOP word and the sequencer state encodings.
package instr_seq_pkg;

    localparam int INSTR_W = 9;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;
    localparam logic [2:0] OP_LI  = 3'b100;

    // AND $0,$0,$0 has no architectural effect on the cpu.
    localparam logic [INSTR_W-1:0] NOP_WORD = '0;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

    function automatic logic is_illegal_op(input logic [2:0] op);
        return (op == 3'b011) || (op == 3'b101);
    endfunction

endpackage

// File: rtl/instr_sequencer_store.sv
// Program store: DEPTH x INSTR_W words, synchronous write, combinational read.
module instr_store
    import instr_seq_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic               clk,
    input  logic               we,
    input  logic [ADDR_W-1:0]  waddr,
    input  logic [INSTR_W-1:0] wdata,
    input  logic [ADDR_W-1:0]  raddr,
    output logic [INSTR_W-1:0] rdata
);

    logic [INSTR_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/instr_sequencer.sv
// Fetch sequencer feeding the 4-bit cpu Instruction port from a loadable program store.
// Optional illegal-opcode trap enabled by defining INSTR_SEQ_ILLEGAL_OP_EN.
module instr_sequencer
    import instr_seq_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic               CLK,
    input  logic               RESET_N,
    input  logic               prog_we,
    input  logic [ADDR_W-1:0]  prog_addr,
    input  logic [INSTR_W-1:0] prog_data,
    input  logic [ADDR_W:0]    prog_len,
    input  logic               start,
    input  logic               abort,
    input  logic               hold,
    output logic [INSTR_W-1:0] Instruction,
    output logic               instr_valid,
    output logic               busy,
    output logic               done,
    output logic [ADDR_W-1:0]  pc
`ifdef INSTR_SEQ_ILLEGAL_OP_EN
    ,
    output logic               error
`endif
);

    localparam logic [ADDR_W:0]   DEPTH_LEN = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   LEN_ONE   = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] PC_ONE    = ADDR_W'(1);

    logic [1:0]         state_reg,  state_next;
    logic [ADDR_W-1:0]  pc_reg,     pc_next;
    logic [ADDR_W:0]    len_reg,    len_next;
    logic [INSTR_W-1:0] instr_reg,  instr_next;
    logic               valid_reg,  valid_next;
`ifdef INSTR_SEQ_ILLEGAL_OP_EN
    logic               error_reg,  error_next;
`endif

    logic [INSTR_W-1:0] mem_word;
    logic [ADDR_W:0]    len_clamped;
    logic               store_we;
    logic               last_word;

    assign store_we    = prog_we && ((state_reg == ST_IDLE) || (state_reg == ST_DONE));
    assign len_clamped = (prog_len > DEPTH_LEN) ? DEPTH_LEN : prog_len;
    assign last_word   = ({1'b0, pc_reg} + LEN_ONE) == len_reg;

    instr_store #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_store (
        .clk   (CLK),
        .we    (store_we),
        .waddr (prog_addr),
        .wdata (prog_data),
        .raddr (pc_reg),
        .rdata (mem_word)
    );

    // Output word and valid default to NOP every cycle; only a real issue overrides them.
    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        len_next   = len_reg;
        instr_next = NOP_WORD;
        valid_next = 1'b0;
`ifdef INSTR_SEQ_ILLEGAL_OP_EN
        error_next = error_reg;
`endif
        case (state_reg)
            ST_IDLE, ST_DONE: begin
                if ((state_reg == ST_DONE) && abort) begin
                    state_next = ST_IDLE;
                    pc_next    = '0;
`ifdef INSTR_SEQ_ILLEGAL_OP_EN
                    error_next = 1'b0;
`endif
                end else if (start) begin
                    len_next   = len_clamped;
                    pc_next    = '0;
                    state_next = (len_clamped == '0) ? ST_DONE : ST_RUN;
`ifdef INSTR_SEQ_ILLEGAL_OP_EN
                    error_next = 1'b0;
`endif
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_next = ST_IDLE;
                    pc_next    = '0;
`ifdef INSTR_SEQ_ILLEGAL_OP_EN
                    error_next = 1'b0;
`endif
                end else if (!hold) begin
`ifdef INSTR_SEQ_ILLEGAL_OP_EN
                    if (is_illegal_op(mem_word[8:6])) begin
                        error_next = 1'b1;
                        state_next = ST_DONE;
                    end else begin
`else
                    begin
`endif
                        instr_next = mem_word;
                        valid_next = 1'b1;
                        pc_next    = pc_reg + PC_ONE;
                        if (last_word) begin
                            state_next = ST_DONE;
                        end
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
                pc_next    = '0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_reg <= ST_IDLE;
            pc_reg    <= '0;
            len_reg   <= '0;
            instr_reg <= NOP_WORD;
            valid_reg <= 1'b0;
`ifdef INSTR_SEQ_ILLEGAL_OP_EN
            error_reg <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            len_reg   <= len_next;
            instr_reg <= instr_next;
            valid_reg <= valid_next;
`ifdef INSTR_SEQ_ILLEGAL_OP_EN
            error_reg <= error_next;
`endif
        end
    end

    assign Instruction = instr_reg;
    assign instr_valid = valid_reg;
    assign busy        = (state_reg == ST_RUN);
    assign done        = (state_reg == ST_DONE);
    assign pc          = pc_reg;
`ifdef INSTR_SEQ_ILLEGAL_OP_EN
    assign error       = error_reg;
`endif

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: directed program runs plus randomized programs, lengths,
// holds and aborts, checked cycle by cycle against a word-count reference model.
module tb_instr_sequencer;
    import instr_seq_pkg::*;

    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;

    logic              CLK = 1'b0;
    logic              RESET_N = 1'b0;
    logic              prog_we = 1'b0;
    logic [ADDR_W-1:0] prog_addr = '0;
    logic [8:0]        prog_data = '0;
    logic [ADDR_W:0]   prog_len = '0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic              hold = 1'b0;
    logic [8:0]        Instruction;
    logic              instr_valid;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] pc;
`ifdef INSTR_SEQ_ILLEGAL_OP_EN
    logic              error;
`endif

    int errors = 0;
    int checks = 0;
    logic [8:0] ref_mem [DEPTH];

    always #5 CLK = ~CLK;

    instr_sequencer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .CLK         (CLK),
        .RESET_N     (RESET_N),
        .prog_we     (prog_we),
        .prog_addr   (prog_addr),
        .prog_data   (prog_data),
        .prog_len    (prog_len),
        .start       (start),
        .abort       (abort),
        .hold        (hold),
        .Instruction (Instruction),
        .instr_valid (instr_valid),
        .busy        (busy),
        .done        (done),
        .pc          (pc)
`ifdef INSTR_SEQ_ILLEGAL_OP_EN
        ,
        .error       (error)
`endif
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag, input logic [8:0] e_instr, input bit e_valid,
                               input bit e_busy, input bit e_done, input int e_pc);
        check({tag, ".instr"}, 32'(Instruction), 32'(e_instr));
        check({tag, ".valid"}, 32'(instr_valid), 32'(e_valid));
        check({tag, ".busy"},  32'(busy),        32'(e_busy));
        check({tag, ".done"},  32'(done),        32'(e_done));
        check({tag, ".pc"},    32'(pc),          32'(e_pc));
`ifdef INSTR_SEQ_ILLEGAL_OP_EN
        check({tag, ".error"}, 32'(error),       32'd0);
`endif
    endtask

    function automatic logic [8:0] legal_word();
        logic [2:0] ops [6];
        ops = '{OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_LI};
        return {ops[$urandom_range(0, 5)], 6'($urandom)};
    endfunction

    // Write one word while the sequencer is IDLE or DONE, so the model copy updates too.
    task automatic load(input int addr, input logic [8:0] data);
        prog_we   = 1'b1;
        prog_addr = ADDR_W'(addr);
        prog_data = data;
        tick();
        prog_we   = 1'b0;
        ref_mem[addr] = data;
    endtask

    // Model: after start, each unheld cycle presents word n and counts it; done shows
    // together with word L-1; pc always equals the count of words issued (mod DEPTH).
    task automatic run(input int plen, input int hold_mode, input int hold_mask,
                       input int abort_after, input bit we_in_run);
        int L;
        int n;
        int cyc;
        bit h;
        bit ab;
        L = (plen > DEPTH) ? DEPTH : plen;
        prog_len = (ADDR_W+1)'(plen);
        start = 1'b1;
        tick();
        start = 1'b0;
        if (L == 0) begin
            check_state("len0", NOP_WORD, 1'b0, 1'b0, 1'b1, 0);
            $display("run len=%0d clamped=%0d issued=0 (empty)", plen, L);
            return;
        end
        check_state("run0", NOP_WORD, 1'b0, 1'b1, 1'b0, 0);
        n = 0;
        cyc = 0;
        while (n < L && cyc < 200) begin
            h  = (hold_mode == 1) ? (((hold_mask >> cyc) & 1) != 0)
               : (hold_mode == 2) ? ($urandom_range(0, 3) == 0) : 1'b0;
            ab = (n == abort_after);
            hold  = h | ab;
            abort = ab;
            if (we_in_run && cyc == 0) begin
                prog_we   = 1'b1;
                prog_addr = ADDR_W'(1);
                prog_data = 9'b111110010;
            end
            tick();
            hold    = 1'b0;
            abort   = 1'b0;
            prog_we = 1'b0;
            if (ab) begin
                check_state("abort", NOP_WORD, 1'b0, 1'b0, 1'b0, 0);
                $display("run len=%0d clamped=%0d aborted after %0d words", plen, L, n);
                return;
            end
            if (h) begin
                check_state("hold", NOP_WORD, 1'b0, 1'b1, 1'b0, n % DEPTH);
`ifdef INSTR_SEQ_ILLEGAL_OP_EN
            end else if (ref_mem[n][8:6] == 3'b011 || ref_mem[n][8:6] == 3'b101) begin
                check("illegal.instr", 32'(Instruction), 32'(NOP_WORD));
                check("illegal.valid", 32'(instr_valid), 32'd0);
                check("illegal.done",  32'(done),        32'd1);
                check("illegal.busy",  32'(busy),        32'd0);
                check("illegal.error", 32'(error),       32'd1);
                $display("run len=%0d clamped=%0d trapped illegal op at word %0d", plen, L, n);
                return;
`endif
            end else begin
                check_state("issue", ref_mem[n], 1'b1, (n + 1) != L, (n + 1) == L, (n + 1) % DEPTH);
                n++;
            end
            cyc++;
        end
        check("run.count", 32'(n), 32'(L));
        tick();
        check_state("post", NOP_WORD, 1'b0, 1'b0, 1'b1, n % DEPTH);
        $display("run len=%0d clamped=%0d issued=%0d cycles=%0d", plen, L, n, cyc);
    endtask

    initial begin
        int plen;
        int ab_at;
        repeat (2) tick();
        check_state("reset", NOP_WORD, 1'b0, 1'b0, 1'b0, 0);
        RESET_N = 1'b1;
        tick();
        check_state("idle", NOP_WORD, 1'b0, 1'b0, 1'b0, 0);

        for (int a = 0; a < DEPTH; a++) load(a, legal_word());
        load(0, 9'b100111110);
        load(1, 9'b100100011);
        load(2, 9'b000101101);
        load(3, 9'b110011011);

        run(4, 0, 0, -1, 1'b0);
        run(4, 1, 32'h2, -1, 1'b0);
        run(4, 0, 0, 2, 1'b0);
        run(4, 0, 0, -1, 1'b0);
        run(0, 0, 0, -1, 1'b0);
        run(20, 0, 0, -1, 1'b0);

        // Write during RUN is dropped; the same write in DONE lands.
        run(4, 0, 0, -1, 1'b1);
        run(4, 0, 0, -1, 1'b0);
        load(1, 9'b111110010);
        run(4, 0, 0, -1, 1'b0);

        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_state("done_abort", NOP_WORD, 1'b0, 1'b0, 1'b0, 0);
        run(3, 2, 0, -1, 1'b0);
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check_state("start_abort", NOP_WORD, 1'b0, 1'b0, 1'b0, 0);

        for (int r = 0; r < 10; r++) begin
            load($urandom_range(0, DEPTH - 1), legal_word());
            plen  = $urandom_range(0, 31);
            ab_at = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : -1;
            run(plen, 2, 0, ab_at, 1'b0);
        end

        prog_len = (ADDR_W+1)'(8);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        RESET_N = 1'b0;
        tick();
        RESET_N = 1'b1;
        check_state("mid_reset", NOP_WORD, 1'b0, 1'b0, 1'b0, 0);

`ifdef INSTR_SEQ_ILLEGAL_OP_EN
        load(2, 9'b011000000);
        run(4, 0, 0, -1, 1'b0);
        load(2, 9'b000101101);
        run(4, 0, 0, -1, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
